rand_tx_sequencer: RTL
======================

RAND_TX_SEQUENCER -- requirements
Module: rand_tx_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the sample buffer depth; legal values are powers of two from 2 to 16.
REQ-002 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst  in  1  SHALL be the synchronous, active-high reset.
REQ-004 start  in  1  SHALL request a burst; sampled only in IDLE.
REQ-005 abort  in  1  SHALL cancel a burst from any state.
REQ-006 seed  in  8  SHALL be the LFSR seed, captured on an accepted start.
REQ-007 count  in  8  SHALL be the burst length in bytes, captured on an accepted start; 0 means 256.
REQ-008 lfsr_num  in  8  SHALL be the LFSR output byte.
REQ-009 lfsr_done  in  1  SHALL mark lfsr_num as a valid new sample.
REQ-010 tx_busy  in  1  SHALL be the UART transmitter busy flag.
REQ-011 lfsr_en  out  1  SHALL be the LFSR step enable.
REQ-012 lfsr_seed_en  out  1  SHALL be the LFSR seed load strobe.
REQ-013 lfsr_seed  out  8  SHALL be the registered seed.
REQ-014 tx_start  out  1  SHALL be the one-cycle transmit request.
REQ-015 tx_data  out  8  SHALL be the byte to transmit, stable from tx_start until tx_busy falls.
REQ-016 busy  out  1  SHALL be high in every state except IDLE.
REQ-017 done  out  1  SHALL be a one-cycle pulse when a burst completes normally.
REQ-018 sent_cnt  out  9  SHALL count the bytes transmitted in the current burst.

Function
REQ-019 The FSM SHALL have the states IDLE, SEED, RUN and FLUSH.
REQ-020 IDLE->SEED SHALL occur on start; in SEED, lfsr_seed_en is high for exactly one cycle, then the FSM goes to RUN.
REQ-021 In RUN, lfsr_en SHALL be high iff gen_left>0 and the FIFO is not full.
REQ-022 A sample SHALL be pushed when lfsr_done=1, lfsr_en=1 and gen_left>0; each push decrements gen_left, which is loaded from count (0 loads 256).
REQ-023 RUN->FLUSH SHALL occur when gen_left reaches 0; FLUSH->IDLE SHALL occur when the FIFO is empty and the transmitter is idle, and done pulses in the cycle IDLE is entered.
REQ-024 The TX side SHALL issue tx_start and pop the FIFO into tx_data when the FIFO is non-empty, tx_busy=0 and tx_pend=0.
REQ-025 tx_start SHALL set tx_pend; tx_pend SHALL clear on the first cycle in which tx_busy=1, so a further tx_start only follows a busy high-then-low sequence.
REQ-026 A FIFO push and pop in the same cycle SHALL both occur with no change in occupancy; a push while full is impossible by REQ-021.
REQ-027 sent_cnt SHALL increment on each tx_start, clear on an accepted start, and hold its value in IDLE.
REQ-028 abort SHALL force IDLE next cycle, flush the FIFO, clear tx_pend, drop lfsr_en, and suppress done; an in-flight UART byte completes on its own.
REQ-029 start while busy=1 SHALL be ignored; if start and abort are both high, abort wins.

Reset
REQ-030 rst SHALL force IDLE, empty the FIFO, and drive lfsr_en=0, lfsr_seed_en=0, lfsr_seed=0, tx_start=0, tx_data=0, busy=0, done=0, sent_cnt=0, tx_pend=0, gen_left=0.
REQ-031 rst mid-burst SHALL behave as an abort, with the additional reset of all outputs.

Configuration
REQ-032 With RAND_TX_SKIP_ZERO_EN defined, a sample with lfsr_num=0x00 SHALL be discarded: no push and no gen_left decrement.
REQ-033 Without RAND_TX_SKIP_ZERO_EN, every valid sample SHALL be pushed.

Structure
REQ-034 A shared package SHALL hold the FSM state enum, the FIFO_DEPTH default and the count-0 value of 256.
REQ-035 The buffer SHALL be a sub-module named rand_tx_fifo (synchronous, registered-output FIFO with full and empty flags).

Verification
REQ-036 seed=0xA5, count=3, lfsr_done every cycle, UART model with 10-cycle busy -> one lfsr_seed_en pulse, three tx_start pulses in LFSR order, sent_cnt=3, a single done pulse.
REQ-037 count=0 -> 256 bytes sent, sent_cnt=256, done pulses once.
REQ-038 Transmitter stalled (tx_busy=1) -> after FIFO_DEPTH pushes, lfsr_en=0 until the first pop.
REQ-039 abort during RUN with 2 bytes buffered -> IDLE next cycle, FIFO empty, no done, no further tx_start.
REQ-040 rst during FLUSH -> all outputs at reset values the next cycle; a subsequent start runs a normal burst.
REQ-041 RAND_TX_SKIP_ZERO_EN defined, 0x00 sample injected -> the zero byte is never transmitted and the byte total still equals count.

Source files
------------

// File: rtl/rand_tx_pkg.sv
// Shared FSM state type, FIFO depth default and burst-length helper for rand_tx_sequencer.
package rand_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEED  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  localparam int FIFO_DEPTH_DEF = 4;
  localparam int COUNT_ZERO_LEN = 256;

  // A programmed count of zero stands for a full 256-byte burst.
  function automatic logic [8:0] burst_len(input logic [7:0] cnt);
    return (cnt == 8'd0) ? 9'(COUNT_ZERO_LEN) : {1'b0, cnt};
  endfunction

endpackage

// File: rtl/rand_tx_fifo.sv
// Synchronous sample FIFO with registered read data, full/empty flags and a flush input.
module rand_tx_fifo
  import rand_tx_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int             AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_cnt;
  logic [W-1:0]  r_rdata;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign full      = (r_cnt == FULL_CNT);
  assign empty     = (r_cnt == '0);
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;
  assign rdata     = r_rdata;

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  // Read data is left alone by flush so a byte already handed to the UART stays valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_rdata  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_rdata  <= r_mem[r_rd_ptr];
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/rand_tx_sequencer.sv
// Bursts LFSR bytes through a FIFO to a UART transmitter.
// Optional feature: define RAND_TX_SKIP_ZERO_EN to discard 0x00 samples.
module rand_tx_sequencer
  import rand_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] seed,
  input  logic [7:0] count,
  input  logic [7:0] lfsr_num,
  input  logic       lfsr_done,
  input  logic       tx_busy,
  output logic       lfsr_en,
  output logic       lfsr_seed_en,
  output logic [7:0] lfsr_seed,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       done,
  output logic [8:0] sent_cnt
);

  state_t     r_state;
  logic [8:0] r_gen_left;
  logic [7:0] r_seed;
  logic       r_tx_start;
  logic       r_tx_pend;
  logic       r_done;
  logic [8:0] r_sent_cnt;

  logic       w_full;
  logic       w_empty;
  logic       w_sample_ok;
  logic       w_lfsr_en;
  logic       w_push;
  logic       w_pop;
  logic       w_active;
  logic [7:0] w_fifo_rdata;

`ifdef RAND_TX_SKIP_ZERO_EN
  assign w_sample_ok = (lfsr_num != 8'h00);
`else
  assign w_sample_ok = 1'b1;
`endif

  assign w_lfsr_en = (r_state == ST_RUN) && (r_gen_left != 9'd0) && !w_full && !abort;
  assign w_push    = lfsr_done && w_lfsr_en && w_sample_ok;
  assign w_active  = (r_state == ST_RUN) || (r_state == ST_FLUSH);
  assign w_pop     = w_active && !w_empty && !tx_busy && !r_tx_pend && !abort;

  rand_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (abort),
    .push  (w_push),
    .wdata (lfsr_num),
    .pop   (w_pop),
    .rdata (w_fifo_rdata),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_gen_left <= '0;
      r_seed     <= '0;
      r_tx_start <= 1'b0;
      r_tx_pend  <= 1'b0;
      r_done     <= 1'b0;
      r_sent_cnt <= '0;
    end else begin
      r_tx_start <= w_pop;
      r_done     <= 1'b0;
      // Pending covers the gap between tx_start and the UART raising busy.
      if (w_pop) begin
        r_tx_pend <= 1'b1;
      end else if (tx_busy) begin
        r_tx_pend <= 1'b0;
      end
      if (r_tx_start) begin
        r_sent_cnt <= r_sent_cnt + 9'd1;
      end
      if (abort) begin
        r_state    <= ST_IDLE;
        r_gen_left <= '0;
        r_tx_pend  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_state    <= ST_SEED;
              r_seed     <= seed;
              r_gen_left <= burst_len(count);
              r_sent_cnt <= '0;
            end
          end
          ST_SEED: r_state <= ST_RUN;
          ST_RUN: begin
            if (w_push) begin
              r_gen_left <= r_gen_left - 9'd1;
              if (r_gen_left == 9'd1) begin
                r_state <= ST_FLUSH;
              end
            end
          end
          ST_FLUSH: begin
            if (w_empty && !tx_busy && !r_tx_pend) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign lfsr_en      = w_lfsr_en;
  assign lfsr_seed_en = (r_state == ST_SEED);
  assign lfsr_seed    = r_seed;
  assign tx_start     = r_tx_start;
  assign tx_data      = w_fifo_rdata;
  assign busy         = (r_state != ST_IDLE);
  assign done         = r_done;
  assign sent_cnt     = r_sent_cnt;

endmodule
